// File: rtl/game_state_ctrl.sv
// Game-flow controller: turns frog top/collision levels into level count, lives,
// timed freeze periods, a game-over hold and a one-cycle frog reset pulse.
module game_state_ctrl #(
   parameter int LIVES       = 3,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Frog_At_Top,
   input  logic       i_Collision,
   input  logic       i_Manual_Reset,
   output logic       o_Reset_Frog,
   output logic [3:0] o_Level_Tens,
   output logic [3:0] o_Level_Ones,
   output logic [1:0] o_Lives,
   output logic [1:0] o_State,
   output logic       o_Freeze
);

   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      DYING     = 2'd1,
      LEVEL_UP  = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   state_t        state_q, state_nxt;
   logic [CW-1:0] hold_cnt, cnt_nxt;
   logic [3:0]    tens_q, tens_nxt, ones_q, ones_nxt;
   logic [1:0]    lives_q, lives_nxt;
   logic          freeze_q, freeze_nxt;
   logic          reset_frog_q, reset_frog_nxt;

   // Inputs are sampled once, then compared against their previous sample.
   logic top_smp, col_smp, man_smp;
   logic top_prev, col_prev, man_prev;
   logic top_ev, col_ev, man_ev;
   logic hold_done;

   assign top_ev    = top_smp & ~top_prev;
   assign col_ev    = col_smp & ~col_prev;
   assign man_ev    = man_smp & ~man_prev;
   assign hold_done = ((state_q == DYING) || (state_q == LEVEL_UP)) && (hold_cnt == HOLD_LAST);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         top_smp      <= 1'b0;
         col_smp      <= 1'b0;
         man_smp      <= 1'b0;
         top_prev     <= 1'b0;
         col_prev     <= 1'b0;
         man_prev     <= 1'b0;
         state_q      <= PLAY;
         hold_cnt     <= '0;
         tens_q       <= 4'd0;
         ones_q       <= 4'd0;
         lives_q      <= LIVES_INIT;
         freeze_q     <= 1'b0;
         reset_frog_q <= 1'b0;
      end else begin
         top_smp      <= i_Frog_At_Top;
         col_smp      <= i_Collision;
         man_smp      <= i_Manual_Reset;
         top_prev     <= top_smp;
         col_prev     <= col_smp;
         man_prev     <= man_smp;
         state_q      <= state_nxt;
         hold_cnt     <= cnt_nxt;
         tens_q       <= tens_nxt;
         ones_q       <= ones_nxt;
         lives_q      <= lives_nxt;
         freeze_q     <= freeze_nxt;
         reset_frog_q <= reset_frog_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = hold_cnt;
      tens_nxt  = tens_q;
      ones_nxt  = ones_q;
      lives_nxt = lives_q;
      if (man_ev) begin
         state_nxt = PLAY;
         cnt_nxt   = '0;
         tens_nxt  = 4'd0;
         ones_nxt  = 4'd0;
         lives_nxt = LIVES_INIT;
      end else begin
         case (state_q)
            PLAY: begin
               // Collision takes precedence over reaching the top in the same cycle.
               if (col_ev) begin
                  cnt_nxt = '0;
                  if (lives_q != 2'd0) begin
                     lives_nxt = lives_q - 2'd1;
                  end
                  if (lives_q <= 2'd1) begin
                     state_nxt = GAME_OVER;
                  end else begin
                     state_nxt = DYING;
                  end
               end else if (top_ev) begin
                  state_nxt = LEVEL_UP;
                  cnt_nxt   = '0;
                  if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                     if (ones_q == 4'd9) begin
                        ones_nxt = 4'd0;
                        tens_nxt = tens_q + 4'd1;
                     end else begin
                        ones_nxt = ones_q + 4'd1;
                     end
                  end
               end
            end
            DYING, LEVEL_UP: begin
               if (hold_done) begin
                  state_nxt = PLAY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = hold_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      freeze_nxt     = (state_nxt != PLAY);
      reset_frog_nxt = man_ev | hold_done;
   end

   assign o_Reset_Frog = reset_frog_q;
   assign o_Level_Tens = tens_q;
   assign o_Level_Ones = ones_q;
   assign o_Lives      = lives_q;
   assign o_State      = state_q;
   assign o_Freeze     = freeze_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle;
// a negedge monitor pops an entry whenever the DUT output tuple changes.
module tb_game_state_ctrl;

   localparam int H  = 4;
   localparam int NL = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       top, col, man;
   logic       o_Reset_Frog;
   logic [3:0] o_Level_Tens, o_Level_Ones;
   logic [1:0] o_Lives, o_State;
   logic       o_Freeze;

   game_state_ctrl #(.LIVES(NL), .HOLD_CYCLES(H)) dut (
      .i_Clk          (clk),
      .i_Rst          (rst),
      .i_Frog_At_Top  (top),
      .i_Collision    (col),
      .i_Manual_Reset (man),
      .o_Reset_Frog   (o_Reset_Frog),
      .o_Level_Tens   (o_Level_Tens),
      .o_Level_Ones   (o_Level_Ones),
      .o_Lives        (o_Lives),
      .o_State        (o_State),
      .o_Freeze       (o_Freeze)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rf;
      logic [3:0] tens;
      logic [3:0] ones;
      logic [1:0] lives;
      logic [1:0] state;
      logic       freeze;
   } out_t;

   typedef struct {
      int    cyc;
      out_t  o;
      string tag;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [3:0] m_tens, m_ones;
   logic [1:0] m_lives, m_state;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string fmt(out_t v);
      return $sformatf("rf=%0d lvl=%0d%0d lives=%0d state=%0d freeze=%0d",
                       v.rf, v.tens, v.ones, v.lives, v.state, v.freeze);
   endfunction

   // Monitor: every change of the output tuple must match the next queued entry.
   out_t cur, last;
   bit   have_last = 1'b0;
   exp_t e;
   always @(negedge clk) begin
      cur = '{rf: o_Reset_Frog, tens: o_Level_Tens, ones: o_Level_Ones,
              lives: o_Lives, state: o_State, freeze: o_Freeze};
      if (!have_last || cur !== last) begin
         have_last = 1'b1;
         last      = cur;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change: got %s at cyc %0d, required no change", fmt(cur), cyc);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e.o || (e.cyc >= 0 && e.cyc != cyc)) begin
               n_err++;
               $display("FAIL %s: got %s at cyc %0d, required %s at cyc %0d",
                        e.tag, fmt(cur), cyc, fmt(e.o), e.cyc);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(int c, bit rf, string tag);
      exp_t x;
      x.cyc = c;
      x.o   = '{rf: rf, tens: m_tens, ones: m_ones, lives: m_lives,
                state: m_state, freeze: (m_state != 2'd0)};
      x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic bump_level();
      if (!(m_tens == 4'd9 && m_ones == 4'd9)) begin
         if (m_ones == 4'd9) begin
            m_ones = 4'd0;
            m_tens = m_tens + 4'd1;
         end else begin
            m_ones = m_ones + 4'd1;
         end
      end
   endtask

   task automatic top_event(int hold, string tag);
      int k;
      k   = cyc;
      top = 1'b1;
      if (m_state == 2'd0) begin
         bump_level();
         m_state = 2'd2;
         expect_at(k + 2, 1'b0, {tag, "_enter"});
         m_state = 2'd0;
         expect_at(k + 2 + H, 1'b1, {tag, "_exit_pulse"});
         expect_at(k + 3 + H, 1'b0, {tag, "_pulse_end"});
      end
      tick(hold);
      top = 1'b0;
      tick(H + 5);
   endtask

   task automatic collide(bit with_top, string tag);
      int k;
      k   = cyc;
      col = 1'b1;
      top = with_top;
      m_lives = m_lives - 2'd1;
      if (m_lives == 2'd0) begin
         m_state = 2'd3;
         expect_at(k + 2, 1'b0, {tag, "_game_over"});
      end else begin
         m_state = 2'd1;
         expect_at(k + 2, 1'b0, {tag, "_enter"});
         m_state = 2'd0;
         expect_at(k + 2 + H, 1'b1, {tag, "_exit_pulse"});
         expect_at(k + 3 + H, 1'b0, {tag, "_pulse_end"});
      end
      tick(1);
      col = 1'b0;
      top = 1'b0;
      tick(H + 5);
   endtask

   task automatic manual(string tag);
      int k;
      k   = cyc;
      man = 1'b1;
      m_tens  = 4'd0;
      m_ones  = 4'd0;
      m_lives = 2'(NL);
      m_state = 2'd0;
      expect_at(k + 2, 1'b1, {tag, "_pulse"});
      expect_at(k + 3, 1'b0, {tag, "_pulse_end"});
      tick(1);
      man = 1'b0;
      tick(4);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      top = 1'b0;
      col = 1'b0;
      man = 1'b0;
      m_tens  = 4'd0;
      m_ones  = 4'd0;
      m_lives = 2'(NL);
      m_state = 2'd0;
      expect_at(-1, 1'b0, "reset_values");
      tick(3);
      rst = 1'b0;
      tick(3);

      // Held top input: exactly one level increment.
      top_event(10, "top_held");

      // Lives run down to game over; top is then ignored; manual reset restores.
      collide(1'b0, "col1");
      collide(1'b0, "col2");
      collide(1'b0, "col3");
      top_event(1, "top_in_game_over");
      manual("man_after_go");

      // Simultaneous top and collision at level 05.
      for (int i = 0; i < 5; i++) top_event(1, "top_to_05");
      collide(1'b1, "col_and_top");
      manual("man_before_count");

      // Count up through the BCD carry to 99, then one saturating event.
      for (int i = 0; i < 99; i++) top_event(1, "top_count");
      top_event(1, "top_sat99");
      manual("man_after_99");

      // Async reset two cycles into DYING: immediate reset values, no pulse.
      top_event(1, "top_pre_rst");
      k   = cyc;
      col = 1'b1;
      m_lives = m_lives - 2'd1;
      m_state = 2'd1;
      expect_at(k + 2, 1'b0, "rst_dying_enter");
      tick(1);
      col = 1'b0;
      tick(3);
      rst = 1'b1;
      m_tens  = 4'd0;
      m_ones  = 4'd0;
      m_lives = 2'(NL);
      m_state = 2'd0;
      expect_at(k + 4, 1'b0, "async_rst_values");
      tick(2);
      rst = 1'b0;
      tick(8);

      // Manual reset while in LEVEL_UP.
      k   = cyc;
      top = 1'b1;
      bump_level();
      m_state = 2'd2;
      expect_at(k + 2, 1'b0, "lu_enter");
      tick(1);
      top = 1'b0;
      tick(2);
      man = 1'b1;
      m_tens  = 4'd0;
      m_ones  = 4'd0;
      m_lives = 2'(NL);
      m_state = 2'd0;
      expect_at(k + 5, 1'b1, "man_in_lu_pulse");
      expect_at(k + 6, 1'b0, "man_in_lu_pulse_end");
      tick(1);
      man = 1'b0;
      tick(H + 6);

      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_expectations: got %0d unmatched, required 0 (next %s)",
                  exp_q.size(), exp_q[0].tag);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
